// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC select and F/D pipeline latch with squash on redirect
// and a saturating count of redirects for debug.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               IMEM_AW  = 12,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_target,
    output logic [IMEM_AW-1:0] address_imem,
    input  logic [WIDTH-1:0]   q_imem,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   fd_pc,
    output logic [WIDTH-1:0]   fd_pc_plus1,
    output logic [WIDTH-1:0]   fd_insn,
    output logic               fd_valid,
    output logic [CNT_W-1:0]   flush_count
);
    logic [WIDTH-1:0] pc_plus1;

    assign pc_plus1     = pc + WIDTH'(1);
    assign address_imem = pc[IMEM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            fd_pc       <= '0;
            fd_pc_plus1 <= '0;
            fd_insn     <= '0;
            fd_valid    <= 1'b0;
            flush_count <= '0;
        end else begin
            // Redirect beats stall: the instruction fetched this cycle is wrong-path.
            if (redirect_valid) begin
                pc          <= redirect_target;
                fd_pc       <= '0;
                fd_pc_plus1 <= '0;
                fd_insn     <= '0;
                fd_valid    <= 1'b0;
            end else if (!stall) begin
                pc          <= pc_plus1;
                fd_pc       <= pc;
                fd_pc_plus1 <= pc_plus1;
                fd_insn     <= q_imem;
                fd_valid    <= 1'b1;
            end
            if (redirect_valid && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a rule-level model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [31:0] pc, fd_pc, fd_pc_plus1, fd_insn;
    logic        fd_valid;
    logic [7:0]  flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the fetch stage should hold, derived from the stated rules.
    longint unsigned m_pc, m_fd_pc, m_fd_p1, m_insn;
    bit              m_valid;
    int              m_cnt;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .address_imem(address_imem), .q_imem(q_imem), .pc(pc),
        .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1), .fd_insn(fd_insn),
        .fd_valid(fd_valid), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign q_imem = 32'h100 + 32'(address_imem);

    function automatic logic [31:0] imem_word(longint unsigned a);
        return 32'h100 + 32'(a % 4096);
    endfunction

    function automatic logic [136:0] model_state();
        return {32'(m_pc), 32'(m_fd_pc), 32'(m_fd_p1), 32'(m_insn), m_valid, 8'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_fd_pc = 0; m_fd_p1 = 0; m_insn = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic tick(input bit s, input bit rv, input logic [31:0] tgt);
        longint unsigned n_pc, n_fd_pc, n_fd_p1, n_insn;
        bit n_valid;
        stall = s; redirect_valid = rv; redirect_target = tgt;
        n_pc = m_pc; n_fd_pc = m_fd_pc; n_fd_p1 = m_fd_p1; n_insn = m_insn; n_valid = m_valid;
        if (rv) begin
            n_pc = tgt; n_fd_pc = 0; n_fd_p1 = 0; n_insn = 0; n_valid = 0;
        end else if (!s) begin
            n_pc = (m_pc + 1) % 64'h1_0000_0000;
            n_fd_pc = m_pc; n_fd_p1 = n_pc; n_insn = imem_word(m_pc); n_valid = 1;
        end
        if (rv && m_cnt < 255) m_cnt++;
        @(posedge clk); #1;
        m_pc = n_pc; m_fd_pc = n_fd_pc; m_fd_p1 = n_fd_p1; m_insn = n_insn; m_valid = n_valid;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0; model_reset();
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 1, 32'h77);
        #2 reset = 1'b1; #1;
        n_checks++;
        if ({pc, fd_valid, fd_insn, flush_count} !== {32'h0, 1'b0, 32'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL async_reset pc=%h v=%b insn=%h cnt=%0d want 0/0/0/0", pc, fd_valid, fd_insn, flush_count);
        end
        n_checks++;
        if ({fd_pc, fd_pc_plus1} !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset_fdpc fd_pc=%h fd_p1=%h want 0", fd_pc, fd_pc_plus1);
        end
        @(posedge clk); #3;
        reset = 1'b0; model_reset();
    endtask

    task automatic test_sequential();
        repeat (4) tick(0, 0, 0);
        n_checks++;
        if ({pc, fd_insn, fd_pc, fd_pc_plus1, fd_valid} !== {32'd4, 32'h103, 32'd3, 32'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL sequential pc=%h insn=%h fd_pc=%h fd_p1=%h v=%b want 4/103/3/4/1", pc, fd_insn, fd_pc, fd_pc_plus1, fd_valid);
        end
        n_checks++;
        if (address_imem !== 12'd4) begin
            n_fail++;
            $display("FAIL address_imem got %h want 4", address_imem);
        end
    endtask

    task automatic test_stall();
        tick(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if ({pc, fd_pc, fd_insn, fd_valid} !== {32'd5, 32'd4, 32'h104, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] pc=%h fd_pc=%h insn=%h v=%b want 5/4/104/1", i, pc, fd_pc, fd_insn, fd_valid);
            end
        end
        tick(0, 0, 0);
        n_checks++;
        if ({pc, fd_pc, fd_insn} !== {32'd6, 32'd5, 32'h105}) begin
            n_fail++;
            $display("FAIL stall_release pc=%h fd_pc=%h insn=%h want 6/5/105", pc, fd_pc, fd_insn);
        end
    endtask

    task automatic test_redirect();
        tick(0, 0, 0); tick(0, 0, 0);
        tick(0, 1, 32'h40);
        n_checks++;
        if ({pc, fd_valid, fd_insn, flush_count} !== {32'h40, 1'b0, 32'h0, 8'd1}) begin
            n_fail++;
            $display("FAIL redirect pc=%h v=%b insn=%h cnt=%0d want 40/0/0/1", pc, fd_valid, fd_insn, flush_count);
        end
        tick(0, 0, 0);
        n_checks++;
        if ({fd_pc, fd_valid, fd_insn, pc} !== {32'h40, 1'b1, 32'h140, 32'h41}) begin
            n_fail++;
            $display("FAIL redirect_target pc=%h fd_pc=%h v=%b insn=%h want 41/40/1/140", pc, fd_pc, fd_valid, fd_insn);
        end
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 32'h20);
        n_checks++;
        if ({pc, fd_valid, fd_pc, flush_count} !== {32'h20, 1'b0, 32'h0, 8'd2}) begin
            n_fail++;
            $display("FAIL redirect_stall pc=%h v=%b fd_pc=%h cnt=%0d want 20/0/0/2", pc, fd_valid, fd_pc, flush_count);
        end
    endtask

    task automatic test_wrap();
        tick(0, 1, 32'hFFFF_FFFF);
        n_checks++;
        if (address_imem !== 12'hFFF) begin
            n_fail++;
            $display("FAIL wrap_addr_hi got %h want fff", address_imem);
        end
        tick(0, 0, 0);
        n_checks++;
        if ({pc, address_imem, fd_pc, fd_pc_plus1, fd_insn} !== {32'h0, 12'h0, 32'hFFFF_FFFF, 32'h0, 32'h10FF}) begin
            n_fail++;
            $display("FAIL wrap pc=%h addr=%h fd_pc=%h fd_p1=%h insn=%h want 0/0/ffffffff/0/10ff", pc, address_imem, fd_pc, fd_pc_plus1, fd_insn);
        end
        tick(0, 1, 32'hABCD_E123);
        n_checks++;
        if ({pc, address_imem} !== {32'hABCD_E123, 12'h123}) begin
            n_fail++;
            $display("FAIL high_bits pc=%h addr=%h want abcde123/123", pc, address_imem);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)), 1, $urandom);
            n_checks++;
            if (model_state() !== {pc, fd_pc, fd_pc_plus1, fd_insn, fd_valid, flush_count}) begin
                n_fail++;
                $display("FAIL saturate[%0d] cnt=%0d want %0d pc=%h want %h", i, flush_count, m_cnt, pc, 32'(m_pc));
            end
        end
        n_checks++;
        if (flush_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_final cnt=%0d want 255", flush_count);
        end
    endtask

    task automatic test_random();
        model_reset();
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 32'($urandom_range(0, 8191)));
            n_checks++;
            if (model_state() !== {pc, fd_pc, fd_pc_plus1, fd_insn, fd_valid, flush_count}) begin
                n_fail++;
                $display("FAIL random[%0d] got pc=%h fd_pc=%h fd_p1=%h insn=%h v=%b cnt=%0d want %h", i, pc, fd_pc, fd_pc_plus1, fd_insn, fd_valid, flush_count, model_state());
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(0, 1, 32'h10); tick(0, 1, 32'h30); tick(0, 0, 0);
        n_checks++;
        if (model_state() !== {pc, fd_pc, fd_pc_plus1, fd_insn, fd_valid, flush_count}) begin
            n_fail++;
            $display("FAIL back_to_back got pc=%h fd_pc=%h insn=%h v=%b want %h", pc, fd_pc, fd_insn, fd_valid, model_state());
        end
    endtask

    task automatic test_reset_midstream();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h55;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({pc, fd_pc, fd_pc_plus1, fd_insn, fd_valid, flush_count} !== 137'h0) begin
            n_fail++;
            $display("FAIL reset_midstream pc=%h fd_pc=%h insn=%h v=%b cnt=%0d want all 0", pc, fd_pc, fd_insn, fd_valid, flush_count);
        end
        reset = 1'b0; model_reset();
        tick(0, 0, 0);
        n_checks++;
        if ({pc, fd_pc, fd_insn, fd_valid} !== {32'd1, 32'd0, 32'h100, 1'b1}) begin
            n_fail++;
            $display("FAIL first_fetch pc=%h fd_pc=%h insn=%h v=%b want 1/0/100/1", pc, fd_pc, fd_insn, fd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_saturate();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
